// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - cuts a sample stream into overlapping, tagged frames
module frame_sequencer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_LEN    = 400,
  parameter int HOP_LEN      = 160,
  parameter int IDX_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SAMPLE_WIDTH-1:0] x_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SAMPLE_WIDTH-1:0] y_out,
  output logic                    out_first,
  output logic                    out_last,
  output logic [IDX_WIDTH-1:0]    frame_idx,
  output logic                    busy
);

  localparam int OVL    = FRAME_LEN - HOP_LEN;
  localparam int RING_D = (OVL > 0) ? OVL : 1;
  localparam int RW     = (RING_D > 1) ? $clog2(RING_D) : 1;
  localparam int PW     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PW-1:0] POS_LAST    = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] POS_RP_LAST = PW'(RING_D - 1);
  localparam logic [RW-1:0] PTR_LAST    = RW'(RING_D - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_REPLAY, S_LIVE} state_t;

  state_t                  state, state_nxt;
  logic [PW-1:0]           pos;
  logic [RW-1:0]           wr_ptr, rd_ptr;
  logic [IDX_WIDTH-1:0]    cur_idx;
  logic [SAMPLE_WIDTH-1:0] ring [RING_D];
  logic [SAMPLE_WIDTH-1:0] src;
  logic                    can_load, live, in_xfer, load, frame_end;

  function automatic logic [RW-1:0] ptr_inc(input logic [RW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + RW'(1);
  endfunction

  assign can_load  = !out_valid || out_ready;
  assign live      = (state == S_FILL) || (state == S_LIVE);
  assign in_ready  = live && can_load;
  assign in_xfer   = in_valid && in_ready;
  assign load      = in_xfer || ((state == S_REPLAY) && can_load);
  // Only live states ever carry the last sample of a frame
  assign frame_end = in_xfer && (pos == POS_LAST);
  assign src       = (state == S_REPLAY) ? ring[rd_ptr] : x_in;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (enable) state_nxt = S_FILL;
      S_FILL, S_LIVE: begin
        if (frame_end) begin
          if (!enable)      state_nxt = S_IDLE;
          else if (OVL > 0) state_nxt = S_REPLAY;
          else              state_nxt = S_LIVE;
        end
      end
      S_REPLAY: if (can_load && (pos == POS_RP_LAST)) state_nxt = S_LIVE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= S_IDLE;
    else if (flush) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y_out     <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      frame_idx <= '0;
      pos       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cur_idx   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      y_out     <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      frame_idx <= '0;
      pos       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cur_idx   <= '0;
    end else begin
      if (state == S_IDLE) begin
        pos     <= '0;
        cur_idx <= '0;
      end
      if (in_xfer && (OVL > 0)) wr_ptr <= ptr_inc(wr_ptr);
      if (load) begin
        y_out     <= src;
        out_first <= (pos == '0);
        out_last  <= (pos == POS_LAST);
        frame_idx <= cur_idx;
        out_valid <= 1'b1;
        pos       <= (pos == POS_LAST) ? '0 : pos + PW'(1);
        if (state == S_REPLAY) rd_ptr <= ptr_inc(rd_ptr);
        // Replay starts at the oldest entry, i.e. just past this cycle's write
        if (frame_end) begin
          rd_ptr  <= ptr_inc(wr_ptr);
          cur_idx <= cur_idx + IDX_WIDTH'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_xfer && !flush) ring[wr_ptr] <= x_in;
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - randomized bench for frame_sequencer against a frame model
module tb_frame_sequencer;

  localparam int SW = 16;
  localparam int IW = 16;
  localparam int F  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en [2], fl [2], iv [2], ordy [2];
  logic ir [2], ov [2], of [2], ol [2], bz [2];
  logic [SW-1:0] xi [2], y [2];
  logic [IW-1:0] fi [2];

  always #5 clk = ~clk;

  frame_sequencer #(.SAMPLE_WIDTH(SW), .FRAME_LEN(F), .HOP_LEN(4), .IDX_WIDTH(IW)) dut_ovl (
    .clk(clk), .rst_n(rst_n), .enable(en[0]), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .x_in(xi[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .y_out(y[0]),
    .out_first(of[0]), .out_last(ol[0]), .frame_idx(fi[0]), .busy(bz[0])
  );

  frame_sequencer #(.SAMPLE_WIDTH(SW), .FRAME_LEN(F), .HOP_LEN(8), .IDX_WIDTH(IW)) dut_hop (
    .clk(clk), .rst_n(rst_n), .enable(en[1]), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .x_in(xi[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .y_out(y[1]),
    .out_first(of[1]), .out_last(ol[1]), .frame_idx(fi[1]), .busy(bz[1])
  );

  int n_cmp = 0;
  int n_err = 0;
  int cur, hop, ovl, outn, run, iv_mode, or_mode;
  bit phase, stall_prev;
  logic [33:0] prev_obs;
  logic [SW-1:0] hist [$];

  function automatic logic [33:0] obs(input int d);
    return {y[d], of[d], ol[d], fi[d]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    hist.delete();
    outn = 0;
    run = 0;
    stall_prev = 1'b0;
  endtask

  task automatic select(input int d);
    cur = d;
    hop = (d == 0) ? 4 : 8;
    ovl = F - hop;
    clear_model();
  endtask

  // Output n of a run is sample (n%F) of frame n/F, i.e. accepted input (n/F)*hop + n%F
  task automatic monitor();
    int d, k, j, ix;
    logic [33:0] o;
    d = cur;
    if (fl[d]) begin
      clear_model();
      return;
    end
    o = obs(d);
    if (stall_prev) check("hold", {29'b0, ov[d], o}, {29'b0, 1'b1, prev_obs});
    if (ov[d] && ordy[d]) begin
      k = outn / F;
      j = outn % F;
      ix = k * hop + j;
      check("src_exists", 64'(ix < hist.size()), 64'd1);
      if (ix < hist.size())
        check("frame_sample", 64'(o), 64'({hist[ix], j == 0, j == F - 1, IW'(k)}));
      if (iv_mode == 0 && or_mode == 0 && (k == 0 || j >= ovl))
        check("latency", 64'(ix), 64'(hist.size() - 1));
      outn++;
    end
    if (iv[d] && ir[d]) hist.push_back(xi[d]);
    if (or_mode == 0 && bz[d]) begin
      if (!ir[d]) run++;
      else if (run > 0) begin
        check("replay_len", 64'(run), 64'(ovl));
        run = 0;
      end
    end
    stall_prev = ov[d] && !ordy[d];
    prev_obs = o;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    phase = ~phase;
    iv[cur]   = (iv_mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
    ordy[cur] = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? phase : ($urandom_range(1) == 1);
    xi[cur]   = SW'($urandom);
  endtask

  task automatic wait_out(input int n, input int lim);
    int c = 0;
    while (outn < n && c < lim) begin tick(); c++; end
    check("wait_out_timeout", 64'(outn >= n), 64'd1);
  endtask

  task automatic wait_hist(input int n, input int lim);
    int c = 0;
    while (hist.size() < n && c < lim) begin tick(); c++; end
    check("wait_in_timeout", 64'(hist.size() >= n), 64'd1);
  endtask

  task automatic wait_idle(input int lim);
    int c = 0;
    while ((bz[cur] || ov[cur]) && c < lim) begin tick(); c++; end
    check("wait_idle_timeout", {62'b0, bz[cur], ov[cur]}, 64'd0);
  endtask

  task automatic wait_replay(input int lim);
    int c = 0;
    while (!(bz[cur] && !ir[cur]) && c < lim) begin tick(); c++; end
    check("wait_replay_timeout", {62'b0, bz[cur], ir[cur]}, 64'd2);
  endtask

  // Drop enable and confirm only whole frames were emitted from exactly the inputs they need
  task automatic finish_run();
    en[cur] = 1'b0;
    wait_idle(300);
    check("whole_frames", 64'(outn % F), 64'd0);
    check("inputs_used", 64'(hist.size()), 64'((outn == 0) ? 0 : F + (outn / F - 1) * hop));
    check("idle_flags", {62'b0, bz[cur], ir[cur]}, 64'd0);
    clear_model();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      en[d] = 1'b0; fl[d] = 1'b0; iv[d] = 1'b0; ordy[d] = 1'b0; xi[d] = '0;
    end
    iv_mode = 0;
    or_mode = 0;
    phase = 1'b0;
    prev_obs = '0;
    select(0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check("reset_state", {27'b0, ov[d], ir[d], bz[d], obs(d)}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Overlapping frames at full throughput
    select(0); iv_mode = 0; or_mode = 0;
    en[0] = 1'b1;
    wait_out(24, 200);
    finish_run();

    // Backpressure: toggling then random out_ready, bursty input
    select(0); iv_mode = 1; or_mode = 1;
    en[0] = 1'b1;
    wait_out(40, 600);
    finish_run();
    select(0); iv_mode = 1; or_mode = 2;
    en[0] = 1'b1;
    wait_out(40, 600);
    finish_run();

    // HOP_LEN == FRAME_LEN: no replay, in_ready never drops
    select(1); iv_mode = 0; or_mode = 0;
    en[1] = 1'b1;
    wait_out(24, 200);
    check("in_ready_high", 64'(run), 64'd0);
    finish_run();

    // enable dropped inside frame 1, then a fresh FILL with index restarted
    select(0); iv_mode = 0; or_mode = 0;
    en[0] = 1'b1;
    wait_hist(10, 100);
    en[0] = 1'b0;
    wait_idle(100);
    check("enable_drop_frames", 64'(outn), 64'd16);
    finish_run();
    en[0] = 1'b1;
    wait_out(8, 100);
    finish_run();

    // flush during replay
    select(0); iv_mode = 1; or_mode = 0;
    en[0] = 1'b1;
    wait_replay(100);
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    check("flush_clear", {62'b0, ov[0], bz[0]}, 64'd0);
    wait_out(24, 300);
    finish_run();

    // asynchronous reset mid-LIVE
    select(0); iv_mode = 0; or_mode = 0;
    en[0] = 1'b1;
    wait_hist(10, 100);
    #2 rst_n = 1'b0;
    #1 check("reset_async", {27'b0, ov[0], ir[0], bz[0], obs(0)}, 64'd0);
    rst_n = 1'b1;
    clear_model();
    wait_out(16, 200);
    finish_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
